// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with grant hold and an
// optional hold-time limit. The winner index is registered and decoded
// into a one-hot grant that is forced to zero whenever no grant is valid.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // A zero MAX_HOLD turns the limit off entirely; otherwise the grant is
    // released on the cycle whose count equals MAX_HOLD-1.
    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state;
    state_t     state_nx;
    logic [2:0] ptr;
    logic [2:0] ptr_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [2:0] id_nx;
    logic       valid_nx;
    logic       preempt_nx;

    logic [7:0] cur_bit;
    logic [7:0] others;
    logic [3:0] idle_pick;
    logic [3:0] hand_pick;
    logic       drop;
    logic       limit;

    // Round-robin search: scan from last+1 upward, wrapping 7->0, and
    // return {found, index} of the first set candidate bit.
    function automatic logic [3:0] rr_find(input logic [7:0] cand,
                                           input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!res[3] && cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign cur_bit   = 8'b0000_0001 << gnt_id;
    assign others    = req & ~cur_bit;
    assign idle_pick = rr_find(req, ptr);
    assign hand_pick = rr_find(others, ptr);
    assign drop      = ~req[gnt_id];
    assign limit     = HOLD_EN && (cnt == HOLD_LAST);

    // Next-state, pointer, counter and grant decisions for IDLE and GRANT.
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        cnt_nx     = cnt;
        id_nx      = gnt_id;
        valid_nx   = gnt_valid;
        preempt_nx = 1'b0;
        case (state)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    state_nx = GRANT;
                    ptr_nx   = idle_pick[2:0];
                    id_nx    = idle_pick[2:0];
                    valid_nx = 1'b1;
                    cnt_nx   = 8'd0;
                end else begin
                    id_nx    = 3'd0;
                    valid_nx = 1'b0;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_nx = IDLE;
                    id_nx    = 3'd0;
                    valid_nx = 1'b0;
                    cnt_nx   = 8'd0;
                end else if (drop || limit) begin
                    if (hand_pick[3]) begin
                        ptr_nx     = hand_pick[2:0];
                        id_nx      = hand_pick[2:0];
                        valid_nx   = 1'b1;
                        cnt_nx     = 8'd0;
                        preempt_nx = limit && !drop;
                    end else if (!drop) begin
                        cnt_nx = 8'd0;
                    end else begin
                        state_nx = IDLE;
                        id_nx    = 3'd0;
                        valid_nx = 1'b0;
                        cnt_nx   = 8'd0;
                    end
                end else begin
                    cnt_nx = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                id_nx    = 3'd0;
                valid_nx = 1'b0;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // State and output registers; the one-hot grant is decoded from the
    // next winner so that gnt, gnt_id and gnt_valid always change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            cnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            gnt       <= 8'h00;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt_id    <= id_nx;
            gnt_valid <= valid_nx;
            preempt   <= preempt_nx;
            gnt       <= valid_nx ? (8'b0000_0001 << id_nx) : 8'h00;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: drives two arbiters (hold limit 4 and limit disabled)
// with shared stimulus and compares them to a behavioural model.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt4, gnt0;
    logic [2:0] id4, id0;
    logic       valid4, valid0;
    logic       pre4, pre0;
    logic [12:0] obs4, obs0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        bit busy;
        int id;
        int last;
        int held;
        bit pre;
    } model_t;

    model_t m4, m0;

    rr_arbiter8 #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt4), .gnt_id(id4), .gnt_valid(valid4), .preempt(pre4)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .gnt(gnt0), .gnt_id(id0), .gnt_valid(valid0), .preempt(pre0)
    );

    assign obs4 = {gnt4, id4, valid4, pre4};
    assign obs0 = {gnt0, id0, valid0, pre0};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Next requester after 'last' in circular order, or -1 if none.
    function automatic int rr_pick(logic [7:0] r, int last);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = (last + k) % 8;
            if (r[idx[2:0]]) return idx;
        end
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s.busy = 0;
        s.id = 0;
        s.last = 7;
        s.held = 0;
        s.pre = 0;
        return s;
    endfunction

    // One clock of arbitration: 'held' counts cycles the winner has owned
    // the resource; the limit fires once it reaches the hold budget.
    function automatic model_t model_next(model_t s, bit e, logic [7:0] r, int hold);
        model_t n;
        int w;
        bit drop;
        bit lim;
        logic [7:0] rest;
        n = s;
        n.pre = 0;
        if (!s.busy) begin
            if (e && r != 8'h00) begin
                w = rr_pick(r, s.last);
                n.busy = 1; n.id = w; n.last = w; n.held = 1;
            end
        end else if (!e) begin
            n.busy = 0;
        end else begin
            drop = !r[s.id[2:0]];
            lim = (hold != 0) && (s.held == hold);
            if (drop || lim) begin
                rest = r;
                rest[s.id[2:0]] = 1'b0;
                w = rr_pick(rest, s.last);
                if (w >= 0) begin
                    n.id = w; n.last = w; n.held = 1;
                    n.pre = lim && !drop;
                end else if (!drop) begin
                    n.held = 1;
                end else begin
                    n.busy = 0;
                end
            end else begin
                n.held = s.held + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [12:0] expv(model_t s);
        logic [7:0] g;
        logic [2:0] i;
        g = 8'h00;
        i = 3'd0;
        if (s.busy) begin
            i = s.id[2:0];
            g = 8'h01 << i;
        end
        return {g, i, s.busy, s.pre};
    endfunction

    // Reference model tracks both arbiters, reset asynchronously like the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 = model_reset();
            m0 = model_reset();
        end else begin
            m4 = model_next(m4, en, req, 4);
            m0 = model_next(m0, en, req, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        req = 8'h00;
        tick();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        n_checks++;
        if (obs4 !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_dut4 got=%h exp=%h", obs4, 13'h0);
        end
        n_checks++;
        if (obs0 !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_dut0 got=%h exp=%h", obs0, 13'h0);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1;
        req = 8'h81;
        tick();
        n_checks++;
        if (obs4 !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL basic_first got=%h exp=%h", obs4, {8'h01, 3'd0, 1'b1, 1'b0});
        end
        req = 8'h80;
        tick();
        n_checks++;
        if (obs4 !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL basic_handoff got=%h exp=%h", obs4, {8'h80, 3'd7, 1'b1, 1'b0});
        end
        req = 8'h00;
        tick();
        n_checks++;
        if (obs4 !== 13'h0 || obs0 !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL basic_release got4=%h got0=%h exp=%h", obs4, obs0, 13'h0);
        end
        n_checks++;
        if (obs0 !== expv(m0)) begin
            n_fail++;
            $display("[TB] FAIL basic_model0 got=%h exp=%h", obs0, expv(m0));
        end
    endtask

    task automatic test_fairness();
        logic [2:0] eid;
        logic [12:0] ev;
        do_reset();
        en = 1'b1;
        req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            tick();
            eid = 3'((c / 4) % 8);
            ev = {8'h01 << eid, eid, 1'b1, (c % 4 == 0) && (c > 0)};
            n_checks++;
            if (obs4 !== ev) begin
                n_fail++;
                $display("[TB] FAIL fair_rotate cyc=%0d got=%h exp=%h", c, obs4, ev);
            end
            n_checks++;
            if (!$onehot(gnt4)) begin
                n_fail++;
                $display("[TB] FAIL fair_onehot cyc=%0d got=%h exp=one-hot", c, gnt4);
            end
            n_checks++;
            if (obs0 !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL fair_nolimit cyc=%0d got=%h exp=%h", c, obs0, {8'h01, 3'd0, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_sole();
        do_reset();
        en = 1'b1;
        req = 8'h10;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (obs4 !== {8'h10, 3'd4, 1'b1, 1'b0} || obs0 !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL sole_hold cyc=%0d got4=%h got0=%h exp=%h", c, obs4, obs0, {8'h10, 3'd4, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_nolimit();
        do_reset();
        en = 1'b1;
        req = 8'h06;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_checks++;
            if (obs0 !== {8'h02, 3'd1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL nolimit_hold cyc=%0d got=%h exp=%h", c, obs0, {8'h02, 3'd1, 1'b1, 1'b0});
            end
            n_checks++;
            if (obs4 !== expv(m4)) begin
                n_fail++;
                $display("[TB] FAIL nolimit_model4 cyc=%0d got=%h exp=%h", c, obs4, expv(m4));
            end
        end
        req = 8'h04;
        tick();
        n_checks++;
        if (obs0 !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL nolimit_drop got=%h exp=%h", obs0, {8'h04, 3'd2, 1'b1, 1'b0});
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b1;
        req = 8'h04;
        tick();
        tick();
        n_checks++;
        if (obs4 !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL enable_grant got=%h exp=%h", obs4, {8'h04, 3'd2, 1'b1, 1'b0});
        end
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs4 !== 13'h0 || obs0 !== 13'h0) begin
                n_fail++;
                $display("[TB] FAIL enable_off cyc=%0d got4=%h got0=%h exp=%h", c, obs4, obs0, 13'h0);
            end
        end
        en = 1'b1;
        req = 8'hFF;
        tick();
        n_checks++;
        if (obs4 !== {8'h08, 3'd3, 1'b1, 1'b0} || obs0 !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL enable_resume got4=%h got0=%h exp=%h", obs4, obs0, {8'h08, 3'd3, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        req = 8'h04;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (obs4 !== 13'h0 || obs0 !== 13'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got4=%h got0=%h exp=%h", obs4, obs0, 13'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        req = 8'hFF;
        tick();
        n_checks++;
        if (obs4 !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL async_first got=%h exp=%h", obs4, {8'h01, 3'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1;
        req = 8'($urandom_range(0, 255));
        for (int c = 0; c < 400; c++) begin
            tick();
            n_checks++;
            if (obs4 !== expv(m4)) begin
                n_fail++;
                $display("[TB] FAIL random_dut4 cyc=%0d got=%h exp=%h", c, obs4, expv(m4));
            end
            n_checks++;
            if (obs0 !== expv(m0)) begin
                n_fail++;
                $display("[TB] FAIL random_dut0 cyc=%0d got=%h exp=%h", c, obs0, expv(m0));
            end
            if ($urandom_range(0, 3) == 0) begin
                req = req ^ 8'($urandom_range(0, 255));
            end
            en = ($urandom_range(0, 15) != 0);
        end
    endtask

    initial begin
        $display("[TB] starting rr_arbiter8 bench");
        test_reset();
        test_basic();
        test_fairness();
        test_sole();
        test_nolimit();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
